// File: rtl/exp_scheduler_if.sv
// Request/response and engine-side signals of the exponent scheduler.
// slave is the scheduler's view; master is the requester/engine side.
interface exp_scheduler_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] x0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] a1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result0;
    logic [WIDTH-1:0] result1;
    logic             err0;
    logic             err1;
    logic             eng_enable;
    logic [WIDTH-1:0] eng_x;
    logic [WIDTH-1:0] eng_a;
    logic [WIDTH-1:0] eng_p;
    logic             eng_ready;
    logic             busy;

    modport slave (
        input  req0, req1, x0, a0, x1, a1, eng_p, eng_ready,
        output done0, done1, result0, result1, err0, err1,
               eng_enable, eng_x, eng_a, busy
    );

    modport master (
        output req0, req1, x0, a0, x1, a1, eng_p, eng_ready,
        input  done0, done1, result0, result1, err0, err1,
               eng_enable, eng_x, eng_a, busy
    );
endinterface

// File: rtl/exp_scheduler.sv
// Round-robin scheduler sharing one exponent engine between two requesters,
// with a per-job watchdog that reports a timed-out job as an error.
module exp_scheduler #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,
    exp_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_DONE,
        RESPOND
    } state_e;

    localparam logic [WIDTH-1:0] WDOG_LAST = WIDTH'(TIMEOUT - 1);

    state_e           state_q,   state_d;
    logic             grant_q,   grant_d;
    logic             last_q,    last_d;
    logic [WIDTH-1:0] eng_x_q,   eng_x_d;
    logic [WIDTH-1:0] eng_a_q,   eng_a_d;
    logic [WIDTH-1:0] result0_q, result0_d;
    logic [WIDTH-1:0] result1_q, result1_d;
    logic [WIDTH-1:0] wdog_q,    wdog_d;
    logic             err_q,     err_d;
    logic             wdog_expired;

    assign wdog_expired = (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            eng_x_q   <= '0;
            eng_a_q   <= '0;
            result0_q <= '0;
            result1_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            eng_x_q   <= eng_x_d;
            eng_a_q   <= eng_a_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        eng_x_d   = eng_x_q;
        eng_a_d   = eng_a_q;
        result0_d = result0_q;
        result1_d = result1_q;
        wdog_d    = wdog_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie, serve whoever was not granted last
                    grant_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    last_d  = grant_d;
                    eng_x_d = grant_d ? bus.x1 : bus.x0;
                    eng_a_d = grant_d ? bus.a1 : bus.a0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.eng_ready) begin
                    wdog_d  = '0;
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                wdog_d = wdog_q + WIDTH'(1);
                if (wdog_expired) begin
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else if (!bus.eng_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wdog_d = wdog_q + WIDTH'(1);
                if (bus.eng_ready) begin
                    if (grant_q) result1_d = bus.eng_p;
                    else         result0_d = bus.eng_p;
                    state_d = RESPOND;
                end else if (wdog_expired) begin
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy       = (state_q != IDLE);
        bus.eng_enable = (state_q == ISSUE) && bus.eng_ready;
        bus.done0      = (state_q == RESPOND) && !grant_q;
        bus.done1      = (state_q == RESPOND) &&  grant_q;
        bus.err0       = (state_q == RESPOND) && !grant_q && err_q;
        bus.err1       = (state_q == RESPOND) &&  grant_q && err_q;
        bus.eng_x      = eng_x_q;
        bus.eng_a      = eng_a_q;
        bus.result0    = result0_q;
        bus.result1    = result1_q;
    end
endmodule

// File: tb/tb_exp_scheduler.sv
// Scoreboard bench for exp_scheduler: directed jobs against a behavioural
// exponent engine with configurable latency, stall and hang.
`timescale 1ns/1ps
module tb_exp_scheduler;
    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exp_scheduler_if #(.WIDTH(W)) bus();

    exp_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         idx;
        logic [W-1:0] x;
        logic [W-1:0] a;
        logic [W-1:0] res;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pw(input logic [W-1:0] b, input logic [W-1:0] e);
        logic [W-1:0] r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    // Engine: accepts eng_enable, drops ready for eng_lat cycles, then returns x**a
    int           eng_lat   = 3;
    logic         eng_hang  = 1'b0;
    logic         eng_stall = 1'b0;
    logic         eng_rdy;
    int           eng_cnt;
    logic [W-1:0] eng_res;

    assign bus.eng_ready = eng_rdy & ~eng_stall;
    assign bus.eng_p     = eng_res;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_rdy <= 1'b1;
            eng_cnt <= 0;
            eng_res <= '0;
        end else if (bus.eng_enable) begin
            eng_cnt <= eng_lat;
            eng_rdy <= 1'b0;
            eng_res <= pw(bus.eng_x, bus.eng_a);
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end else begin
            eng_cnt <= 0;
            if (!eng_hang) eng_rdy <= 1'b1;
        end
    end

    // Monitor
    int           en_cnt = 0;
    int           en_cyc = 0;
    logic [W-1:0] last_res [2];
    exp_t         e;
    int           g;

    always @(negedge clk) begin
        if (reset) begin
            en_cnt      = 0;
            last_res[0] = '0;
            last_res[1] = '0;
        end else begin
            check("err_qualified", {bus.err0 & ~bus.done0, bus.err1 & ~bus.done1}, 0);
            if (bus.eng_enable) begin
                en_cnt++;
                en_cyc = cyc;
                check("job_pending_at_enable", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("eng_x", bus.eng_x, sb[0].x);
                    check("eng_a", bus.eng_a, sb[0].a);
                end
            end
            if (bus.done0 || bus.done1) begin
                check("single_done", bus.done0 & bus.done1, 0);
                check("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    g = bus.done1 ? 1 : 0;
                    check("done_idx", g, e.idx);
                    check("result", g ? bus.result1 : bus.result0, e.res);
                    check("err", g ? bus.err1 : bus.err0, e.err);
                    check("enable_count", en_cnt, 1);
                    check("latency", cyc - en_cyc, e.lat);
                    check("other_result_held", g ? bus.result0 : bus.result1, last_res[g ? 0 : 1]);
                    last_res[g] = e.res;
                end
                en_cnt = 0;
            end
        end
    end

    logic [W-1:0] jx [2][4];
    logic [W-1:0] ja [2][4];

    task automatic push_exp(input int idx, input logic [W-1:0] x, input logic [W-1:0] a,
                            input logic [W-1:0] res, input logic err, input int lat);
        exp_t t;
        t.idx = idx; t.x = x; t.a = a; t.res = res; t.err = err; t.lat = lat;
        sb.push_back(t);
    endtask

    task automatic requester(input int idx, input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            if (idx == 0) begin
                bus.x0 = jx[0][k]; bus.a0 = ja[0][k]; bus.req0 = 1'b1;
            end else begin
                bus.x1 = jx[1][k]; bus.a1 = ja[1][k]; bus.req1 = 1'b1;
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(idx == 0 ? bus.done0 : bus.done1) && t < 200);
            check("done_within_bound", t < 200, 1);
            @(posedge clk);
            #1;
        end
        if (idx == 0) bus.req0 = 1'b0;
        else          bus.req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_eng_enable"}, bus.eng_enable, 0);
        check({tag, "_done"},       {bus.done0, bus.done1}, 0);
        check({tag, "_err"},        {bus.err0, bus.err1},   0);
        check({tag, "_result0"},    bus.result0,    0);
        check({tag, "_result1"},    bus.result1,    0);
        check({tag, "_eng_x"},      bus.eng_x,      0);
        check({tag, "_eng_a"},      bus.eng_a,      0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected < 10000", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int t;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.x0 = '0; bus.a0 = '0; bus.x1 = '0; bus.a1 = '0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single job: 3**4
        eng_lat = 3;
        jx[0][0] = 3; ja[0][0] = 4;
        push_exp(0, 3, 4, 81, 1'b0, 5);
        requester(0, 1);
        @(negedge clk);
        check("single_result0", bus.result0, 81);
        check("single_result1_zero", bus.result1, 0);
        check("single_idle", bus.busy, 0);

        // Tie out of reset: requester 0 first
        do_reset();
        jx[0][0] = 5; ja[0][0] = 2;
        jx[1][0] = 2; ja[1][0] = 5;
        push_exp(0, 5, 2, 25, 1'b0, 5);
        push_exp(1, 2, 5, 32, 1'b0, 5);
        fork
            requester(0, 1);
            requester(1, 1);
        join

        // Fairness: both held for four jobs
        jx[0][0] = 2; ja[0][0] = 3; jx[0][1] = 3; ja[0][1] = 3;
        jx[1][0] = 4; ja[1][0] = 2; jx[1][1] = 2; ja[1][1] = 10;
        push_exp(0, 2, 3,   8, 1'b0, 5);
        push_exp(1, 4, 2,  16, 1'b0, 5);
        push_exp(0, 3, 3,  27, 1'b0, 5);
        push_exp(1, 2, 10, 1024, 1'b0, 5);
        fork
            requester(0, 2);
            requester(1, 2);
        join

        // Timeout: engine never returns, result0 stays 27
        eng_hang = 1'b1;
        jx[0][0] = 7; ja[0][0] = 2;
        push_exp(0, 7, 2, 27, 1'b1, TO + 1);
        requester(0, 1);
        eng_hang = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("timeout_result0_kept", bus.result0, 27);

        // Stall at ISSUE
        eng_lat = 2;
        eng_stall = 1'b1;
        jx[0][0] = 2; ja[0][0] = 4;
        push_exp(0, 2, 4, 16, 1'b0, 4);
        fork
            requester(0, 1);
            begin
                repeat (7) @(negedge clk);
                check("stall_no_enable", en_cnt, 0);
                check("stall_busy", bus.busy, 1);
                @(posedge clk);
                #1;
                eng_stall = 1'b0;
            end
        join

        // Reset in WAIT_DONE
        eng_lat = 10;
        push_exp(0, 4, 4, 256, 1'b0, 12);
        bus.x0 = 4; bus.a0 = 4; bus.req0 = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.eng_enable && t < 50);
        check("midjob_enable_seen", t < 50, 1);
        repeat (3) @(negedge clk);
        check("midjob_busy", bus.busy, 1);
        #2;
        reset = 1'b1;
        bus.req0 = 1'b0;
        sb.delete();
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_idle", bus.busy, 0);

        // Tie after reset again goes to requester 0
        eng_lat = 3;
        jx[0][0] = 2; ja[0][0] = 2;
        jx[1][0] = 3; ja[1][0] = 2;
        push_exp(0, 2, 2, 4, 1'b0, 5);
        push_exp(1, 3, 2, 9, 1'b0, 5);
        @(posedge clk);
        #1;
        fork
            requester(0, 1);
            requester(1, 1);
        join

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
